// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types and constants for the memory-port arbiter: FSM state
//            encoding, grant owner encoding and the legal MEM_LAT range.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Which requester currently owns (or last owned) the memory port
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Legal memory latency range and the countdown width that covers it
  localparam int c_MEM_LAT_MIN = 1;
  localparam int c_MEM_LAT_MAX = 4;
  localparam int c_CNT_W       = 2;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundle of the CPU requester, DMA requester and memory-side
//            signals. "slave" is the arbiter view, "master" the environment.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_done;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic [31:0]   dma_rdata;
  logic          dma_ack;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/memarb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : memarb_rr_pick
// Brief    : Grant selection for the memory-port arbiter. A lone requester
//            always wins. On a collision the CPU wins, unless MEMARB_FAIR_EN
//            is defined, in which case the requester that did not own the
//            previous grant wins (round-robin).
// Config   : MEMARB_FAIR_EN - enables round-robin collision resolution
// Revision : 1.0 - initial release
// ============================================================================
module memarb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_cpu_req,
  input  logic   i_dma_req,
  input  owner_t i_last_owner,
  output owner_t o_owner
);

`ifdef MEMARB_FAIR_EN
  // Collision goes to whoever did not win last time
  always_comb begin
    o_owner = OWN_CPU;
    if (i_cpu_req && i_dma_req) begin
      o_owner = (i_last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (i_dma_req) begin
      o_owner = OWN_DMA;
    end
  end
`else
  // Fixed priority has no use for the grant history
  logic w_unused_last_owner;
  assign w_unused_last_owner = (i_last_owner == OWN_DMA);

  // CPU has fixed priority; DMA wins only when alone
  always_comb begin
    o_owner = OWN_CPU;
    if (i_dma_req && !i_cpu_req) begin
      o_owner = OWN_DMA;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one fixed-latency data-memory port between a CPU and a
//            DMA/debug requester. Each access runs IDLE -> BUSY (MEM_LAT
//            cycles of strobe) -> DONE (one-cycle completion pulse).
// Config   : MEMARB_FAIR_EN - round-robin collision resolution (default:
//            CPU priority)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  // Reject latencies the countdown cannot represent
  generate
    if (MEM_LAT < c_MEM_LAT_MIN || MEM_LAT > c_MEM_LAT_MAX) begin : g_lat_check
      $error("mem_port_arbiter: MEM_LAT out of range");
    end
  endgenerate

  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LAT - 1);

  state_t             r_state;
  logic [c_CNT_W-1:0] r_count;
  owner_t             r_owner;
  owner_t             r_last_owner;
  logic               r_we;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic [AW-1:0]      r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [31:0]        r_cpu_rdata;
  logic [31:0]        r_dma_rdata;
  logic               r_cpu_done;
  logic               r_dma_ack;

  owner_t             w_pick;
  logic               w_any_req;
  logic               w_pick_we;
  logic [AW-1:0]      w_pick_addr;
  logic [31:0]        w_pick_wdata;

  memarb_rr_pick u_pick (
    .i_cpu_req    (bus.cpu_req),
    .i_dma_req    (bus.dma_req),
    .i_last_owner (r_last_owner),
    .o_owner      (w_pick)
  );

  assign w_any_req = bus.cpu_req | bus.dma_req;

  // Route the winning requester's command fields toward the latch
  always_comb begin
    w_pick_we    = bus.cpu_we;
    w_pick_addr  = bus.cpu_addr;
    w_pick_wdata = bus.cpu_wdata;
    if (w_pick == OWN_DMA) begin
      w_pick_we    = bus.dma_we;
      w_pick_addr  = bus.dma_addr;
      w_pick_wdata = bus.dma_wdata;
    end
  end

  // Access FSM: latch command in IDLE, strobe memory in BUSY, pulse in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_we         <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_cpu_done   <= 1'b0;
      r_dma_ack    <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_dma_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            r_we         <= w_pick_we;
            r_mem_addr   <= w_pick_addr;
            r_mem_wdata  <= w_pick_wdata;
            r_count      <= c_CNT_INIT;
            r_mem_rd     <= ~w_pick_we;
            r_mem_wr     <= w_pick_we;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (r_count == '0) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            // Load data is only valid in the final BUSY cycle
            if (!r_we) begin
              if (r_owner == OWN_CPU) begin
                r_cpu_rdata <= bus.mem_rdata;
              end else begin
                r_dma_rdata <= bus.mem_rdata;
              end
            end
            if (r_owner == OWN_CPU) begin
              r_cpu_done <= 1'b1;
            end else begin
              r_dma_ack <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_done  = r_cpu_done;
  assign bus.cpu_stall = bus.cpu_req & ~r_cpu_done;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
